// File: rtl/temp_conv_seq_if.sv
// Conversion request/result bundle: operand, unit select and load/start in; result and status out.
interface temp_conv_seq_if #(
  parameter int W  = 8,
  parameter int QW = 10
);
  logic signed [W-1:0]  X;
  logic [1:0]           sel;
  logic                 ld;
  logic                 st;
  logic signed [QW-1:0] Q;
  logic                 busy;
  logic                 done;
  logic                 ovf;

  modport master (output X, sel, ld, st, input Q, busy, done, ovf);
  modport slave  (input X, sel, ld, st, output Q, busy, done, ovf);
endinterface

// File: rtl/temp_conv_seq.sv
// Celsius -> F/C/K converter; done 2 cycles after st (C/K) or W+6 cycles (F, serial /5); ld/st ignored while busy.
// Define TEMP_CONV_SAT_EN to clamp out-of-range results instead of wrapping (ovf is raised either way).
module temp_conv_seq #(
  parameter int W  = 8,
  parameter int QW = 10
) (
  input  logic            clk,
  input  logic            clr,
  temp_conv_seq_if.slave  bus
);
  localparam int NW = W + 4;
  localparam int RW = (W + 10 > QW) ? W + 10 : QW + 1;
  localparam int CW = $clog2(NW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [RW-1:0] QMAX = {{(RW-QW+1){1'b0}}, {(QW-1){1'b1}}};
  localparam logic signed [RW-1:0] QMIN = {{(RW-QW+1){1'b1}}, {(QW-1){1'b0}}};
  localparam logic signed [RW-1:0] K273 = RW'(273);

  logic [1:0]           state_q, state_d;
  logic signed [W-1:0]  op_q, op_d;
  logic [1:0]           sel_q, sel_d;
  logic [NW-1:0]        dvd_q, dvd_d;
  logic [3:0]           rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic signed [QW-1:0] q_q, q_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [NW-1:0]        op_n, n_val, n_abs, quo;
  logic [4:0]           rem_sh;
  logic                 rem_ge;
  logic signed [RW-1:0] op_ext, res;
  logic                 res_hi, res_lo;
  logic signed [QW-1:0] q_fit;

  // N = 9*op + 160, so F = N / 5 truncated toward zero
  assign op_n   = {{4{op_q[W-1]}}, op_q};
  assign n_val  = (op_n << 3) + op_n + NW'(160);
  assign n_abs  = n_val[NW-1] ? (~n_val + NW'(1)) : n_val;
  assign rem_sh = {rem_q, dvd_q[NW-1]};
  assign rem_ge = (rem_sh >= 5'd5);
  assign quo    = neg_q ? (~dvd_q + NW'(1)) : dvd_q;
  assign op_ext = {{(RW-W){op_q[W-1]}}, op_q};

  always_comb begin
    res = op_ext;
    case (sel_q)
      2'b00:   res = {{(RW-NW){quo[NW-1]}}, quo};
      2'b01:   res = op_ext;
      default: res = op_ext + K273;
    endcase
  end

  assign res_hi = (res > QMAX);
  assign res_lo = (res < QMIN);

`ifdef TEMP_CONV_SAT_EN
  assign q_fit = res_hi ? QMAX[QW-1:0] : (res_lo ? QMIN[QW-1:0] : res[QW-1:0]);
`else
  assign q_fit = res[QW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    q_d     = q_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ld) op_d = bus.X;
        if (bus.st) begin
          sel_d   = bus.sel;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        dvd_d   = n_abs;
        neg_d   = n_val[NW-1];
        rem_d   = 4'd0;
        cnt_d   = '0;
        state_d = (sel_q == 2'b00) ? S_DIV : S_DONE;
      end
      S_DIV: begin
        // dividend shifts out the top while quotient bits fill in from the bottom
        dvd_d = {dvd_q[NW-2:0], rem_ge};
        rem_d = rem_ge ? (rem_sh[3:0] - 4'd5) : rem_sh[3:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NW-1)) state_d = S_DONE;
      end
      default: begin
        q_d     = q_fit;
        ovf_d   = res_hi | res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sel_q   <= 2'b00;
      dvd_q   <= '0;
      rem_q   <= 4'd0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_temp_conv_seq.sv
// Directed bench: a QW=10 and a QW=8 converter share the same stimulus; expected values are hand-computed.
module tb_temp_conv_seq;
  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic signed [7:0] x = '0;
  logic [1:0]      sel = 2'b00;
  logic            ld = 1'b0;
  logic            st = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  temp_conv_seq_if #(.W(8), .QW(10)) a ();
  temp_conv_seq_if #(.W(8), .QW(8))  b ();

  assign a.X = x;   assign a.sel = sel; assign a.ld = ld; assign a.st = st;
  assign b.X = x;   assign b.sel = sel; assign b.ld = ld; assign b.st = st;

  temp_conv_seq #(.W(8), .QW(10)) dut  (.clk(clk), .clr(clr), .bus(a));
  temp_conv_seq #(.W(8), .QW(8))  dut8 (.clk(clk), .clr(clr), .bus(b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Returns at the negedge where done is seen; lat counts cycles after the st edge.
  task automatic wait_done(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      st = 1'b0;
      ld = 1'b0;
      if (a.done) begin
        lat = k;
        return;
      end
      bc += int'(a.busy);
    end
  endtask

  task automatic go(input int xv, input logic [1:0] s, input bit do_ld, input bit sep_ld,
                    output int lat, output int bc);
    if (do_ld) begin
      ld = 1'b1;
      x  = 8'(xv);
      if (sep_ld) begin
        @(negedge clk);
        ld = 1'b0;
      end
    end
    st  = 1'b1;
    sel = s;
    wait_done(lat, bc);
  endtask

  int lat, bc, nd, qd, ld_lat;

  initial begin
    #1;
    check("rst_q",    a.Q,    0);
    check("rst_busy", a.busy, 0);
    check("rst_done", a.done, 0);
    check("rst_ovf",  a.ovf,  0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    go(37, 2'b00, 1, 1, lat, bc);
    check("f37_lat",  lat, 14);
    check("f37_busy", bc,  14);
    check("f37_q",    a.Q, 98);
    check("f37_ovf",  a.ovf, 0);
    check("f37_busy_at_done", a.busy, 0);
    check("f37_q8",   b.Q, 98);
    @(negedge clk);
    check("f37_done_pulse", a.done, 0);
    check("f37_q_hold", a.Q, 98);

    go(-40, 2'b00, 1, 1, lat, bc);
    check("fm40_q", a.Q, -40);
    check("fm40_ovf", a.ovf, 0);
    go(100, 2'b00, 1, 1, lat, bc);
    check("f100_q", a.Q, 212);
    check("f100_ovf", a.ovf, 0);
`ifdef TEMP_CONV_SAT_EN
    check("f100_q8", b.Q, 127);
`else
    check("f100_q8", b.Q, -44);
`endif
    check("f100_ovf8", b.ovf, 1);

    go(127, 2'b10, 1, 0, lat, bc);
    check("k127_lat", lat, 2);
    check("k127_q",   a.Q, 400);
    check("k127_ovf", a.ovf, 0);
`ifdef TEMP_CONV_SAT_EN
    check("k127_q8", b.Q, 127);
`else
    check("k127_q8", b.Q, -112);
`endif
    check("k127_ovf8", b.ovf, 1);
    go(-128, 2'b01, 1, 0, lat, bc);
    check("cm128_b2b_lat", lat, 2);
    check("cm128_q",  a.Q, -128);
    check("cm128_q8", b.Q, -128);
    check("cm128_ovf8", b.ovf, 0);

    // ld/st/sel activity while busy must not disturb the conversion in flight
    ld = 1'b1; x = 8'sd37;
    @(negedge clk);
    ld = 1'b0; st = 1'b1; sel = 2'b00;
    nd = 0; qd = 0; ld_lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      st = 1'b0;
      ld = 1'b0;
      if (a.done) begin
        nd++;
        qd = a.Q;
        ld_lat = k;
      end
      if (k == 3) begin
        ld = 1'b1; st = 1'b1; x = 8'sd5; sel = 2'b01;
      end
    end
    check("busy_ign_ndone", nd, 1);
    check("busy_ign_lat", ld_lat, 14);
    check("busy_ign_q", qd, 98);
    go(0, 2'b01, 0, 0, lat, bc);
    check("operand_kept", a.Q, 37);

    // reset in the middle of a Fahrenheit conversion
    ld = 1'b1; x = 8'sd37;
    @(negedge clk);
    ld = 1'b0; st = 1'b1; sel = 2'b00;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      st = 1'b0;
    end
    clr = 1'b0;
    #1;
    check("clr_q",    a.Q,    0);
    check("clr_busy", a.busy, 0);
    check("clr_done", a.done, 0);
    check("clr_ovf",  a.ovf,  0);
    @(negedge clk);
    clr = 1'b1;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (a.done) nd++;
    end
    check("clr_no_done", nd, 0);
    check("clr_q_after", a.Q, 0);
    go(0, 2'b00, 0, 0, lat, bc);
    check("post_clr_lat", lat, 14);
    check("post_clr_q",   a.Q, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
